// File: rtl/probe_drop_pkg.sv
// Shared types and helpers for the RX buffer drop-probe event serializer.
// Region vectors are carried at a fixed maximum width; unused upper bits stay zero.
package probe_drop_pkg;

  localparam int PD_MAX_REGIONS = 16;
  localparam int PD_IDX_W       = 4;
  localparam int PD_PTR_W       = 5;

  localparam logic [PD_PTR_W-1:0] PD_PTR_ONE = {{(PD_PTR_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  typedef logic [PD_MAX_REGIONS-1:0] region_vec_t;

  typedef struct packed {
    region_vec_t eof;
    region_vec_t drop;
  } probe_word_t;

  typedef struct packed {
    logic                found;
    logic [PD_IDX_W-1:0] idx;
  } first_set_t;

  function automatic logic [PD_PTR_W-1:0] popcount(input region_vec_t vec);
    logic [PD_PTR_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < PD_MAX_REGIONS; i++) begin
      cnt = cnt + PD_PTR_W'(vec[i]);
    end
    return cnt;
  endfunction

  // Scans downward so the lowest qualifying bit is the one left in res
  function automatic first_set_t first_set_from(input region_vec_t vec,
                                                input logic [PD_PTR_W-1:0] start);
    first_set_t res;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = PD_MAX_REGIONS - 1; i >= 0; i--) begin
      if (vec[i] && (i >= int'(start))) begin
        res.found = 1'b1;
        res.idx   = PD_IDX_W'(i);
      end
    end
    return res;
  endfunction

  function automatic logic any_set_from(input region_vec_t vec,
                                        input logic [PD_PTR_W-1:0] start);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PD_MAX_REGIONS; i++) begin
      hit = hit | (vec[i] & (i >= int'(start)));
    end
    return hit;
  endfunction

endpackage

// File: rtl/probe_drop_fifo.sv
// Register-array synchronous FIFO with extended pointers. Exposes a look-ahead
// view of next cycle's head and emptiness so the consumer can register its outputs.
module probe_drop_fifo #(
  parameter int WIDTH = 8,
  parameter int ITEMS = 16,
  localparam int AW   = $clog2(ITEMS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             empty_nxt,
  output logic [WIDTH-1:0] rd_data_nxt
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [ITEMS];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_nxt_s;
  logic [AW:0]      rd_ptr_nxt_s;
  logic             empty_s;
  logic             do_wr_s;
  logic             do_rd_s;

  // Status flags, guarded strobes and look-ahead head selection
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_rd_s = rd_en && !empty_s;
    do_wr_s = wr_en && (!full || do_rd_s);
    wr_ptr_nxt_s = do_wr_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    rd_ptr_nxt_s = do_rd_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    empty_nxt    = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    // A word written into the slot about to become head is not yet in mem_r
    if (do_wr_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      rd_data_nxt = wr_data;
    end else begin
      rd_data_nxt = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
    end
  end

  // Storage array; contents are don't-care while the pointers mark them empty
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/probe_drop_event_serializer.sv
// Turns multi-region drop-probe words into one pass/drop event per frame,
// lowest region first, and keeps saturating frame/drop/lost statistics.
module probe_drop_event_serializer
  import probe_drop_pkg::*;
#(
  parameter int REGIONS    = 4,
  parameter int FIFO_ITEMS = 16,
  parameter int CNT_WIDTH  = 32,
  localparam int RW        = (REGIONS > 1) ? $clog2(REGIONS) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 PROBE_SRC_RDY,
  input  logic [REGIONS-1:0]   PROBE_EOF,
  input  logic [REGIONS-1:0]   PROBE_DROP,
  output logic                 EV_SRC_RDY,
  input  logic                 EV_DST_RDY,
  output logic                 EV_DROP,
  output logic [RW-1:0]        EV_REGION,
  input  logic                 CNT_CLR,
  output logic [CNT_WIDTH-1:0] CNT_FRAMES,
  output logic [CNT_WIDTH-1:0] CNT_DROPS,
  output logic [CNT_WIDTH-1:0] CNT_LOST
);

  localparam int WW = 2 * REGIONS;

  logic [WW-1:0]        wr_data_s;
  logic [WW-1:0]        fifo_head_nxt_s;
  logic                 full_s;
  logic                 fifo_empty_nxt_s;
  logic                 wr_valid_s;
  logic                 wr_en_s;
  logic                 lost_s;
  region_vec_t          probe_eof_s;
  region_vec_t          probe_drop_s;
  logic                 xfer_s;
  logic                 pop_s;
  logic [PD_PTR_W-1:0]  after_s;
  logic [PD_PTR_W-1:0]  ptr_nxt_s;
  probe_word_t          head_nxt_s;
  first_set_t           nxt_ev_s;
  logic                 emit_nxt_s;
  logic [0:0]           state_nxt_s;

  logic [0:0]           state_r;
  logic [PD_PTR_W-1:0]  ptr_r;
  region_vec_t          head_eof_r;
  logic [RW-1:0]        ev_region_r;
  logic                 ev_drop_r;
  logic [CNT_WIDTH-1:0] cnt_frames_r;
  logic [CNT_WIDTH-1:0] cnt_drops_r;
  logic [CNT_WIDTH-1:0] cnt_lost_r;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PD_PTR_W-1:0]  inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + (CNT_WIDTH + 1)'(inc);
    if (sum[CNT_WIDTH]) begin
      return {CNT_WIDTH{1'b1}};
    end else begin
      return sum[CNT_WIDTH-1:0];
    end
  endfunction

  // Head walk: transfer advances past the emitted bit, exhausting the word pops it
  always_comb begin
    xfer_s  = (state_r == ST_EMIT) && EV_DST_RDY;
    after_s = PD_PTR_W'(ev_region_r) + PD_PTR_ONE;
    pop_s   = xfer_s && !any_set_from(head_eof_r, after_s);
    if (pop_s) begin
      ptr_nxt_s = '0;
    end else if (xfer_s) begin
      ptr_nxt_s = after_s;
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Probe capture; a slot freed by a same-cycle pop is usable by the write
  always_comb begin
    probe_eof_s                 = '0;
    probe_drop_s                = '0;
    probe_eof_s[REGIONS-1:0]    = PROBE_EOF;
    probe_drop_s[REGIONS-1:0]   = PROBE_DROP & PROBE_EOF;
    wr_data_s                   = {PROBE_EOF, PROBE_DROP & PROBE_EOF};
    wr_valid_s                  = PROBE_SRC_RDY && (|PROBE_EOF);
    wr_en_s                     = wr_valid_s && (!full_s || pop_s);
    lost_s                      = wr_valid_s && full_s && !pop_s;
  end

  probe_drop_fifo #(
    .WIDTH (WW),
    .ITEMS (FIFO_ITEMS)
  ) u_fifo (
    .clk         (CLK),
    .rst         (RESET),
    .wr_en       (wr_en_s),
    .wr_data     (wr_data_s),
    .rd_en       (pop_s),
    .full        (full_s),
    .empty_nxt   (fifo_empty_nxt_s),
    .rd_data_nxt (fifo_head_nxt_s)
  );

  // Next event from next cycle's head and pointer, so outputs come straight from flops
  always_comb begin
    head_nxt_s                   = '0;
    head_nxt_s.eof[REGIONS-1:0]  = fifo_head_nxt_s[WW-1:REGIONS];
    head_nxt_s.drop[REGIONS-1:0] = fifo_head_nxt_s[REGIONS-1:0];
    nxt_ev_s                     = first_set_from(head_nxt_s.eof, ptr_nxt_s);
    emit_nxt_s                   = !fifo_empty_nxt_s && nxt_ev_s.found;
    case (state_r)
      ST_IDLE: state_nxt_s = emit_nxt_s ? ST_EMIT : ST_IDLE;
      ST_EMIT: state_nxt_s = emit_nxt_s ? ST_EMIT : ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Walker state and registered event outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      head_eof_r  <= '0;
      ev_region_r <= '0;
      ev_drop_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      if (emit_nxt_s) begin
        head_eof_r  <= head_nxt_s.eof;
        ev_region_r <= RW'(nxt_ev_s.idx);
        ev_drop_r   <= head_nxt_s.drop[nxt_ev_s.idx];
      end else begin
        head_eof_r  <= '0;
        ev_region_r <= '0;
        ev_drop_r   <= 1'b0;
      end
    end
  end

  // Saturating statistics; clear wins over same-cycle increments
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_frames_r <= '0;
      cnt_drops_r  <= '0;
      cnt_lost_r   <= '0;
    end else if (CNT_CLR) begin
      cnt_frames_r <= '0;
      cnt_drops_r  <= '0;
      cnt_lost_r   <= '0;
    end else begin
      if (wr_en_s) begin
        cnt_frames_r <= sat_add(cnt_frames_r, popcount(probe_eof_s));
        cnt_drops_r  <= sat_add(cnt_drops_r, popcount(probe_drop_s));
      end
      if (lost_s) begin
        cnt_lost_r <= sat_add(cnt_lost_r, popcount(probe_eof_s));
      end
    end
  end

  assign EV_SRC_RDY = (state_r == ST_EMIT);
  assign EV_REGION  = ev_region_r;
  assign EV_DROP    = ev_drop_r;
  assign CNT_FRAMES = cnt_frames_r;
  assign CNT_DROPS  = cnt_drops_r;
  assign CNT_LOST   = cnt_lost_r;

endmodule

// File: tb/tb_probe_drop_event_serializer.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized phase against a queue-based event model.
module tb_probe_drop_event_serializer;

  localparam int REGIONS    = 4;
  localparam int FIFO_ITEMS = 16;
  localparam int CNT_WIDTH  = 6;
  localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b1;
  logic                 PROBE_SRC_RDY = 1'b0;
  logic [REGIONS-1:0]   PROBE_EOF = '0;
  logic [REGIONS-1:0]   PROBE_DROP = '0;
  logic                 EV_DST_RDY = 1'b0;
  logic                 CNT_CLR = 1'b0;
  logic                 EV_SRC_RDY;
  logic                 EV_DROP;
  logic [1:0]           EV_REGION;
  logic [CNT_WIDTH-1:0] CNT_FRAMES;
  logic [CNT_WIDTH-1:0] CNT_DROPS;
  logic [CNT_WIDTH-1:0] CNT_LOST;

  probe_drop_event_serializer #(
    .REGIONS    (REGIONS),
    .FIFO_ITEMS (FIFO_ITEMS),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PROBE_SRC_RDY (PROBE_SRC_RDY),
    .PROBE_EOF     (PROBE_EOF),
    .PROBE_DROP    (PROBE_DROP),
    .EV_SRC_RDY    (EV_SRC_RDY),
    .EV_DST_RDY    (EV_DST_RDY),
    .EV_DROP       (EV_DROP),
    .EV_REGION     (EV_REGION),
    .CNT_CLR       (CNT_CLR),
    .CNT_FRAMES    (CNT_FRAMES),
    .CNT_DROPS     (CNT_DROPS),
    .CNT_LOST      (CNT_LOST)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: flat queue of pending events plus per-word event counts
  typedef struct {
    int region;
    int drop;
  } ev_t;
  ev_t ev_q[$];
  int  len_q[$];
  int  m_frames, m_drops, m_lost;
  int  xfer_cnt;
  int  xfer_regions[$];

  typedef struct {
    logic       src;
    logic [3:0] eof;
    logic [3:0] drop;
    logic       dst;
    logic       clr;
    logic       e_valid;
    int         e_region;
    logic       e_drop;
    int         e_frames;
    int         e_drops;
    int         e_lost;
  } vec_t;
  vec_t tbl[20];

  function automatic int sat(input int a, input int b);
    return (a + b > CNT_MAX) ? CNT_MAX : a + b;
  endfunction

  task automatic model_reset();
    ev_q.delete();
    len_q.delete();
    m_frames = 0;
    m_drops  = 0;
    m_lost   = 0;
  endtask

  task automatic model_step();
    int  nf, nd;
    ev_t e;
    if (ev_q.size() > 0 && EV_DST_RDY) begin
      void'(ev_q.pop_front());
      len_q[0] = len_q[0] - 1;
      if (len_q[0] == 0) void'(len_q.pop_front());
    end
    nf = $countones(PROBE_EOF);
    nd = $countones(PROBE_EOF & PROBE_DROP);
    if (CNT_CLR) begin
      m_frames = 0;
      m_drops  = 0;
      m_lost   = 0;
    end
    if (PROBE_SRC_RDY && nf > 0) begin
      if (len_q.size() < FIFO_ITEMS) begin
        for (int i = 0; i < REGIONS; i++) begin
          if (PROBE_EOF[i]) begin
            e.region = i;
            e.drop   = int'(PROBE_DROP[i]);
            ev_q.push_back(e);
          end
        end
        len_q.push_back(nf);
        if (!CNT_CLR) begin
          m_frames = sat(m_frames, nf);
          m_drops  = sat(m_drops, nd);
        end
      end else if (!CNT_CLR) begin
        m_lost = sat(m_lost, nf);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("ev_src_rdy", int'(EV_SRC_RDY), (ev_q.size() > 0) ? 1 : 0);
    if (ev_q.size() > 0) begin
      check("ev_region", int'(EV_REGION), ev_q[0].region);
      check("ev_drop", int'(EV_DROP), ev_q[0].drop);
    end
    check("cnt_frames", int'(CNT_FRAMES), m_frames);
    check("cnt_drops", int'(CNT_DROPS), m_drops);
    check("cnt_lost", int'(CNT_LOST), m_lost);
  endtask

  task automatic set_in(input logic src, input logic [3:0] eof, input logic [3:0] drop,
                        input logic dst, input logic clr);
    PROBE_SRC_RDY = src;
    PROBE_EOF     = eof;
    PROBE_DROP    = drop;
    EV_DST_RDY    = dst;
    CNT_CLR       = clr;
  endtask

  task automatic cycle();
    if (EV_SRC_RDY && EV_DST_RDY) begin
      xfer_cnt++;
      xfer_regions.push_back(int'(EV_REGION));
    end
    model_step();
    @(posedge CLK);
    #1;
    check_model();
  endtask

  task automatic idle(input int n, input logic dst);
    set_in(1'b0, 4'b0000, 4'b0000, dst, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'b0101, 4'b0100, 1'b1, 1'b0, 1'b1, 0, 1'b0, 2, 1, 0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 1'b1, 2, 1, 0};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2, 1, 0};
    tbl[3]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2, 1, 0};
    tbl[4]  = '{1'b1, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b1, 3, 1'b1, 3, 2, 0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 3, 1'b1, 3, 2, 0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3, 2, 0};
    tbl[7]  = '{1'b1, 4'b0110, 4'b0010, 1'b1, 1'b0, 1'b1, 1, 1'b1, 5, 3, 0};
    tbl[8]  = '{1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 1'b0, 6, 3, 0};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 1'b0, 6, 3, 0};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 6, 3, 0};
    tbl[11] = '{1'b1, 4'b0011, 4'b0011, 1'b1, 1'b1, 1'b1, 0, 1'b1, 0, 0, 0};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 0, 0, 0};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0};
    tbl[14] = '{1'b1, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b1, 0, 1'b0, 4, 2, 0};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 4, 2, 0};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 1'b1, 4, 2, 0};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 1'b0, 4, 2, 0};
    tbl[18] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 3, 1'b1, 4, 2, 0};
    tbl[19] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4, 2, 0};

    // Reset state
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ev_src_rdy", int'(EV_SRC_RDY), 0);
    check("rst_ev_region", int'(EV_REGION), 0);
    check("rst_ev_drop", int'(EV_DROP), 0);
    check("rst_cnt_frames", int'(CNT_FRAMES), 0);
    check("rst_cnt_drops", int'(CNT_DROPS), 0);
    check("rst_cnt_lost", int'(CNT_LOST), 0);
    RESET = 1'b0;

    // Directed vector table
    foreach (tbl[k]) begin
      set_in(tbl[k].src, tbl[k].eof, tbl[k].drop, tbl[k].dst, tbl[k].clr);
      model_step();
      @(posedge CLK);
      #1;
      check($sformatf("tbl%0d_valid", k), int'(EV_SRC_RDY), int'(tbl[k].e_valid));
      if (tbl[k].e_valid) begin
        check($sformatf("tbl%0d_region", k), int'(EV_REGION), tbl[k].e_region);
        check($sformatf("tbl%0d_drop", k), int'(EV_DROP), int'(tbl[k].e_drop));
      end
      check($sformatf("tbl%0d_frames", k), int'(CNT_FRAMES), tbl[k].e_frames);
      check($sformatf("tbl%0d_drops", k), int'(CNT_DROPS), tbl[k].e_drops);
      check($sformatf("tbl%0d_lost", k), int'(CNT_LOST), tbl[k].e_lost);
    end

    // Overflow: 17 single-frame words into a stalled 16-deep FIFO
    set_in(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) cycle();
    check("ovf_frames", int'(CNT_FRAMES), 16);
    check("ovf_lost", int'(CNT_LOST), 1);
    xfer_cnt = 0;
    idle(30, 1'b1);
    check("ovf_events", xfer_cnt, 16);

    // Full FIFO with pop and write in the same cycle loses nothing
    set_in(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    cycle();
    set_in(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle();
    xfer_cnt = 0;
    set_in(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    check("fullpop_lost", int'(CNT_LOST), 0);
    check("fullpop_frames", int'(CNT_FRAMES), 21);
    idle(30, 1'b1);
    check("fullpop_events", xfer_cnt, 21);

    // Random stalls on four-frame words: region order per word is 0,1,2,3
    xfer_regions.delete();
    for (int i = 0; i < 60; i++) begin
      set_in(1'($urandom_range(0, 1)), 4'b1111, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'b0);
      cycle();
    end
    idle(80, 1'b1);
    check("order_nonempty", (xfer_regions.size() > 0) ? 1 : 0, 1);
    foreach (xfer_regions[k]) check($sformatf("order%0d", k), xfer_regions[k], k % 4);

    // Saturation of the frame and drop counters, then clear beats a same-cycle word
    set_in(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle();
    for (int i = 0; i < 15; i++) begin
      set_in(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0);
      cycle();
      idle(3, 1'b1);
    end
    set_in(1'b1, 4'b0011, 4'b0011, 1'b1, 1'b0);
    cycle();
    idle(3, 1'b1);
    check("sat_pre_frames", int'(CNT_FRAMES), CNT_MAX - 1);
    check("sat_pre_drops", int'(CNT_DROPS), CNT_MAX - 1);
    set_in(1'b1, 4'b0011, 4'b0011, 1'b1, 1'b0);
    cycle();
    idle(3, 1'b1);
    check("sat_frames", int'(CNT_FRAMES), CNT_MAX);
    check("sat_drops", int'(CNT_DROPS), CNT_MAX);
    set_in(1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    cycle();
    idle(3, 1'b1);
    check("sat_hold", int'(CNT_FRAMES), CNT_MAX);
    set_in(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1);
    cycle();
    check("clr_frames", int'(CNT_FRAMES), 0);
    check("clr_drops", int'(CNT_DROPS), 0);
    idle(4, 1'b1);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
      cycle();
    end
    idle(80, 1'b1);

    // Reset while events are pending
    set_in(1'b1, 4'b1111, 4'b0101, 1'b0, 1'b0);
    cycle();
    check("pre_rst_valid", int'(EV_SRC_RDY), 1);
    set_in(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_valid", int'(EV_SRC_RDY), 0);
    check("midrst_region", int'(EV_REGION), 0);
    check("midrst_drop", int'(EV_DROP), 0);
    check("midrst_frames", int'(CNT_FRAMES), 0);
    check("midrst_drops", int'(CNT_DROPS), 0);
    check("midrst_lost", int'(CNT_LOST), 0);
    model_reset();
    #2;
    RESET = 1'b0;
    idle(5, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
